binary_bcd_converter: RTL and testbench

BINARY_BCD_CONVERTER -- requirements
Module: binary_bcd_converter

---
 rtl/binary_bcd_converter_pkg.sv | 18 +
 rtl/binary_bcd_converter_add3.sv | 11 +
 rtl/binary_bcd_converter.sv | 101 ++++++++++
 tb/tb_binary_bcd_converter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/binary_bcd_converter_pkg.sv
// Shared constants and state encoding for the shift-and-add-3 binary-to-BCD converter.
package binary_bcd_converter_pkg;

    localparam int DIGIT_W   = 4;
    localparam int DIGIT_CNT = 3;
    localparam int SCRATCH_W = DIGIT_W * DIGIT_CNT;
    localparam int CNT_W     = 4;

    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADD3_VALUE  = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/binary_bcd_converter_add3.sv
// One BCD digit correction: add 3 when the digit would overflow past 9 after doubling.
module bcd_add3
    import binary_bcd_converter_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= ADD3_THRESH) ? digit_i + ADD3_VALUE : digit_i;

endmodule

// File: rtl/binary_bcd_converter.sv
// Sequential double-dabble converter: one bit per SHIFT cycle, result digits
// registered and updated only on the cycle that raises Done.
module binary_bcd_converter
    import binary_bcd_converter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    input  logic [N-1:0] Bin,
    output logic         Busy,
    output logic         Done,
    output logic [3:0]   BCD2,
    output logic [3:0]   BCD1,
    output logic [3:0]   BCD0
);

    state_t                 state_q, state_d;
    logic [N-1:0]           bin_q, bin_d;
    logic [SCRATCH_W-1:0]   scratch_q, scratch_d;
    logic [SCRATCH_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_q, done_d;

    logic [SCRATCH_W-1:0]   scratch_adj;
    logic [SCRATCH_W+N-1:0] shifted;

    for (genvar g = 0; g < DIGIT_CNT; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .digit_o (scratch_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign shifted = {scratch_adj, bin_q} << 1;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    bin_d     = Bin;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(N);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[SCRATCH_W+N-1 -: SCRATCH_W];
                bin_d     = shifted[N-1:0];
                cnt_d     = cnt_q - CNT_W'(1);
                // Last bit: publish the post-shift scratch directly.
                if (cnt_q == CNT_W'(1)) begin
                    result_d = shifted[SCRATCH_W+N-1 -: SCRATCH_W];
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (Reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

    assign Busy = (state_q != IDLE);
    assign Done = done_q;
    assign BCD0 = result_q[0*DIGIT_W +: DIGIT_W];
    assign BCD1 = result_q[1*DIGIT_W +: DIGIT_W];
    assign BCD2 = result_q[2*DIGIT_W +: DIGIT_W];

endmodule

// File: tb/tb_binary_bcd_converter.sv
// Scoreboard bench: stimulus pushes expected digits and Done cycle, a monitor pops on each Done.
module tb_binary_bcd_converter;

    typedef struct {
        logic [11:0] bcd;
        int          cyc;
    } exp_t;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic [7:0] Bin;
    logic       Busy;
    logic       Done;
    logic [3:0] BCD2, BCD1, BCD0;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;
    int          n_push  = 0;
    int          cyc     = 0;
    logic        rst_seen = 1'b0;
    logic [11:0] held = '0;

    binary_bcd_converter #(.N(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .Bin   (Bin),
        .Busy  (Busy),
        .Done  (Done),
        .BCD2  (BCD2),
        .BCD1  (BCD1),
        .BCD0  (BCD0)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        cyc      = cyc + 1;
        rst_seen = Reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: reset clears outputs, Done pops the scoreboard, otherwise outputs must hold.
    always @(negedge Clock) begin
        exp_t e;
        if (rst_seen) begin
            check("reset_outputs", {18'd0, Busy, Done, BCD2, BCD1, BCD0}, 32'd0);
            held = '0;
        end else if (Done === 1'b1) begin
            n_done++;
            check("digit_range", {31'd0, (BCD2 <= 4'd9) && (BCD1 <= 4'd9) && (BCD0 <= 4'd9)}, 32'd1);
            check("busy_in_done", {31'd0, Busy}, 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_done", {31'd0, Done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", {20'd0, BCD2, BCD1, BCD0}, {20'd0, e.bcd});
                check("latency", cyc, e.cyc);
            end
            held = {BCD2, BCD1, BCD0};
        end else begin
            check("hold", {20'd0, BCD2, BCD1, BCD0}, {20'd0, held});
        end
    end

    task automatic push_exp(input logic [11:0] bcd, input int done_cyc);
        exp_t e;
        e.bcd = bcd;
        e.cyc = done_cyc;
        exp_q.push_back(e);
        n_push++;
    endtask

    // Start is accepted on the next edge; Done rises 8 edges after that.
    task automatic start_conv(input logic [7:0] b, input logic [11:0] bcd, input bit keep);
        @(posedge Clock);
        #2;
        Start = 1'b1;
        Bin   = b;
        push_exp(bcd, cyc + 9);
        if (!keep) begin
            @(posedge Clock);
            #2;
            Start = 1'b0;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (Busy === 1'b1) n++;
            else break;
        end
        if (n >= 40) check("idle_timeout", {31'd0, Busy}, 32'd0);
    endtask

    task automatic wait_done(output int m);
        m = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clock);
            if (Done === 1'b1) begin
                m = cyc;
                break;
            end
        end
        if (m < 0) check("done_timeout", {31'd0, Done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  vin  [7];
        logic [11:0] vexp [7];
        int          n;
        int          m;

        vin  = '{8'd0,   8'd255,  8'd128,  8'd99,   8'd10,   8'd5,    8'd63};
        vexp = '{12'h000, 12'h255, 12'h128, 12'h099, 12'h010, 12'h005, 12'h063};

        Start = 1'b0;
        Bin   = '0;
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #2;
        Reset = 1'b0;
        @(negedge Clock);
        check("idle_after_reset", {31'd0, Busy}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            start_conv(vin[i], vexp[i], 1'b0);
            wait_idle(n);
            check("busy_cycles", n, 32'd9);
        end

        // Second Start (and Bin change) during a conversion must be ignored.
        start_conv(8'd200, 12'h200, 1'b0);
        repeat (2) @(posedge Clock);
        #2;
        Start = 1'b1;
        Bin   = 8'd17;
        @(posedge Clock);
        #2;
        Start = 1'b0;
        Bin   = 8'd55;
        wait_idle(n);
        @(negedge Clock);
        check("ignored_start_idle", {31'd0, Busy}, 32'd0);

        // Abort a conversion of 255 with reset on its 4th edge: no Done expected.
        @(posedge Clock);
        #2;
        Start = 1'b1;
        Bin   = 8'd255;
        @(posedge Clock);
        #2;
        Start = 1'b0;
        repeat (3) @(posedge Clock);
        #2;
        Reset = 1'b1;
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        @(negedge Clock);
        check("abort_idle", {31'd0, Busy}, 32'd0);
        repeat (12) @(negedge Clock);
        start_conv(8'd42, 12'h042, 1'b0);
        wait_idle(n);

        // Start coincident with Reset is ignored.
        @(posedge Clock);
        #2;
        Reset = 1'b1;
        Start = 1'b1;
        Bin   = 8'd99;
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        Start = 1'b0;
        @(negedge Clock);
        check("start_with_reset", {31'd0, Busy}, 32'd0);

        // Start held high: a new operand each Done, Done pulses 10 cycles apart.
        start_conv(8'd0, 12'h000, 1'b1);
        for (int v = 0; v < 256; v++) begin
            wait_done(m);
            if (v < 255) begin
                Bin = 8'(v + 1);
                push_exp({4'((v + 1) / 100), 4'(((v + 1) / 10) % 10), 4'((v + 1) % 10)}, m + 10);
            end else begin
                Start = 1'b0;
            end
        end
        wait_idle(n);
        repeat (3) @(negedge Clock);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("done_count", n_done, n_push);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
